// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_pkg
// Purpose: Shared definitions for the pipeline hazard controller: memory
//          handshake FSM state encoding, forwarding-select codes, the
//          hard-wired zero register number and the forwarding helper.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // M-stage result wins over W-stage result; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       regwrite_m,
    input logic [4:0] writereg_m,
    input logic       regwrite_w,
    input logic [4:0] writereg_w
  );
    if (regwrite_m && (writereg_m != REG_ZERO) && (writereg_m == src))
      return FWD_M;
    else if (regwrite_w && (writereg_w != REG_ZERO) && (writereg_w == src))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : mem_wait_timer
// Purpose: Wait-state counter for the data-memory handshake. clear loads 1
//          (the first wait cycle), enable counts up, expired flags that the
//          count has reached TIMEOUT.
// Ports  : clk, reset (async, active-high), clear, enable -> expired
// Rev    : 1.0 - initial release
// ============================================================================
module mem_wait_timer
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= 8'd0;
    else if (clear)
      count <= 8'd1;
    // Holding at TIMEOUT keeps the 8-bit count from wrapping.
    else if (enable && (count != TIMEOUT_VAL))
      count <= count + 8'd1;
  end

  assign expired = (count == TIMEOUT_VAL);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module : pipeline_hazard_controller
// Purpose: Stall/flush/forward sequencer for the 5-stage pipeline, plus the
//          M-stage data-memory request/ack handshake with timeout.
// Ports  : clk, reset (async, active-high)
//          rs_d/rt_d, rs_e/rt_e, writereg_e/m/w, regwrite_e/m/w, memtoreg_e,
//          memaccess_m, branch_taken_d, dmem_ack            (inputs)
//          dmem_req, stall_f/d/e/m, flush_d/e, fwd_a_e/fwd_b_e,
//          bus_error, stall_cycles                           (outputs)
// Rev    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       writereg_e,
  input  logic [4:0]       writereg_m,
  input  logic [4:0]       writereg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             memaccess_m,
  input  logic             branch_taken_d,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t state, state_next;
  logic   timer_clear, timer_en, timer_expired;
  logic   mem_stall, load_use;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  assign fwd_a_e = fwd_sel(rs_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
  assign fwd_b_e = fwd_sel(rt_e, regwrite_m, writereg_m, regwrite_w, writereg_w);

  assign load_use = memtoreg_e && regwrite_e && (writereg_e != REG_ZERO) &&
                    ((writereg_e == rs_d) || (writereg_e == rt_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    mem_stall   = 1'b0;
    dmem_req    = 1'b0;
    bus_error   = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;

    case (state)
      ST_RUN: begin
        dmem_req = memaccess_m;
        // A same-cycle ack completes with zero wait states.
        if (memaccess_m && !dmem_ack) begin
          state_next  = ST_MEM_WAIT;
          timer_clear = 1'b1;
          mem_stall   = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        timer_en = 1'b1;
        // Ack wins over an expiring timer; the stall drops in the ack cycle.
        if (dmem_ack) begin
          state_next = ST_RUN;
        end else begin
          mem_stall = 1'b1;
          if (timer_expired)
            state_next = ST_ERROR;
        end
      end
      ST_ERROR: begin
        mem_stall = 1'b1;
        bus_error = 1'b1;
      end
      default: state_next = ST_RUN;
    endcase

    // A memory freeze holds every stage and suppresses bubbles; otherwise a
    // load-use hazard holds F/D and drops a bubble into E.
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end

    // A branch seen while D is held is re-evaluated once D advances.
    flush_d = branch_taken_d && !stall_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall_f && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_pipeline_hazard_controller
// Purpose: Directed-vector scoreboard bench for pipeline_hazard_controller.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic             regwrite_e, regwrite_m, regwrite_w, memtoreg_e;
  logic             memaccess_m, branch_taken_d, dmem_ack;
  logic             dmem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             bus_error;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memaccess_m(memaccess_m),
    .branch_taken_d(branch_taken_d), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .bus_error(bus_error),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [11:0]      outs;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               tests = 0;
  int               fails = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  // {req, sf, sd, se, sm, fd, fe, fa[1:0], fb[1:0], be}
  function automatic logic [11:0] ov(input logic req, sf, sd, se, sm, fd, fe,
                                     input logic [1:0] fa, fb, input logic be);
    return {req, sf, sd, se, sm, fd, fe, fa, fb, be};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0;
    memaccess_m = 0; branch_taken_d = 0; dmem_ack = 0;
  endtask

  // Pushes the expected outputs for the current cycle; the stall counter
  // expectation is the number of stall_f cycles before this one, saturating.
  task automatic expect_out(input string nm, input logic [11:0] v);
    exp_t e;
    e.name = nm;
    e.outs = v;
    e.cnt  = model_cnt;
    sb.push_back(e);
    if (v[10] && (model_cnt != {CNT_W{1'b1}}))
      model_cnt = model_cnt + 1'b1;
  endtask

  // Monitor: compares every scheduled expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = sb.pop_front();
      act = {dmem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
             fwd_a_e, fwd_b_e, bus_error};
      tests++;
      if (act !== e.outs) begin
        fails++;
        $display("FAIL %s outputs: got %b expected %b", e.name, act, e.outs);
      end
      tests++;
      if (stall_cycles !== e.cnt) begin
        fails++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [11:0] ZERO   = 12'b0;
  logic [11:0] freeze_req, lu_stall, err_out;

  initial begin
    freeze_req = ov(1, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    lu_stall   = ov(0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    err_out    = ov(0, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1);
    reset = 1'b1;
    idle();

    // 1. reset state
    tick(); model_cnt = '0; expect_out("reset", ZERO);
    tick(); reset = 1'b0;   expect_out("idle_after_reset", ZERO);

    // 2. forwarding
    tick(); regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 5; rs_e = 5;
    expect_out("fwd_m_prio", ov(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    tick(); writereg_w = 6; rs_e = 6; rt_e = 5;
    expect_out("fwd_w_a_m_b", ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
    tick(); writereg_m = 0; writereg_w = 0; rs_e = 0; rt_e = 0;
    expect_out("fwd_reg0", ZERO);
    tick(); regwrite_m = 0; regwrite_w = 0; writereg_m = 5; writereg_w = 5; rs_e = 5; rt_e = 5;
    expect_out("fwd_no_we", ZERO);

    // 3. load-use and branch flush
    tick(); idle(); memtoreg_e = 1; regwrite_e = 1; writereg_e = 7; rt_d = 7;
    expect_out("load_use", lu_stall);
    tick(); branch_taken_d = 1;
    expect_out("lu_drops_branch", lu_stall);
    tick(); memtoreg_e = 0;
    expect_out("branch_flush", ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    tick(); memtoreg_e = 1; branch_taken_d = 0; writereg_e = 0; rt_d = 0;
    expect_out("lu_reg0", ZERO);
    tick(); idle(); expect_out("idle3", ZERO);

    // 4. memory access acked on the 4th cycle
    tick(); memaccess_m = 1;
    expect_out("mem_run", freeze_req);
    tick(); expect_out("mem_wait1", freeze_req);
    tick(); expect_out("mem_wait2", freeze_req);
    tick(); dmem_ack = 1;
    expect_out("mem_ack", ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    tick(); idle(); expect_out("mem_done", ZERO);

    // ack arriving exactly at the timeout count wins; counter saturates
    tick(); memaccess_m = 1; expect_out("tie_run", freeze_req);
    for (int i = 1; i <= 3; i++) begin
      tick(); expect_out($sformatf("tie_wait%0d", i), freeze_req);
    end
    tick(); dmem_ack = 1;
    expect_out("tie_ack_wins", ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    tick(); idle(); expect_out("tie_done_sat", ZERO);

    // 5. timeout into ERROR
    tick(); memaccess_m = 1; expect_out("to_run", freeze_req);
    for (int i = 1; i <= 4; i++) begin
      tick(); expect_out($sformatf("to_wait%0d", i), freeze_req);
    end
    tick(); expect_out("error", err_out);
    tick(); memaccess_m = 0; dmem_ack = 1; branch_taken_d = 1;
    expect_out("error_sticky", err_out);
    tick(); idle(); reset = 1; model_cnt = '0; expect_out("error_reset", ZERO);
    tick(); reset = 0; expect_out("after_error_reset", ZERO);

    // asynchronous reset in the middle of a wait
    tick(); memaccess_m = 1; expect_out("mr_run", freeze_req);
    tick(); expect_out("mr_wait", freeze_req);
    tick(); memaccess_m = 0; reset = 1; model_cnt = '0;
    expect_out("mid_wait_reset", ZERO);
    tick(); reset = 0; expect_out("mr_idle", ZERO);

    // 6. load-use during a memory wait: freeze first, then the load-use stall
    tick(); memaccess_m = 1; memtoreg_e = 1; regwrite_e = 1; writereg_e = 7; rs_d = 7;
    expect_out("lu_mem_run", freeze_req);
    tick(); expect_out("lu_mem_wait", freeze_req);
    tick(); dmem_ack = 1;
    expect_out("lu_mem_ack", ov(1, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    tick(); memaccess_m = 0; dmem_ack = 0;
    expect_out("lu_after_mem", lu_stall);
    tick(); idle(); expect_out("final_idle", ZERO);

    tick();
    @(negedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
